uart_config_frame: RTL and testbench

Second-generation UART configuration loader. It receives a framed, checksummed configuration word of parametrised width over a single RX line and presents it as a parallel register. Unlike the fixed 52-bit first-generation loader, it:
- frames each load with a header byte and an XOR checksum;
- supports repeated reloads;
- recovers from errors without a reset;
- reports an error cause code.

It sits between the board UART pin and the configurable fabric's config register input.

---
 rtl/uart_config_frame_if.sv | 40 ++++
 rtl/uart_config_frame.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_config_frame.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_config_frame_if.sv
// Serial-in / parallel-config bundle for uart_config_frame.
// The uart_tx line exists only when UART_CFG_ACK_EN is defined.
interface uart_config_frame_if #(
  parameter int CONFIG_WIDTH = 52
);
  logic                    i_uart_rx;
  logic [CONFIG_WIDTH-1:0] o_config_bits;
  logic                    o_config_done;
  logic                    o_config_update;
  logic                    o_config_error;
  logic [2:0]              o_error_code;
  logic                    o_busy;
`ifdef UART_CFG_ACK_EN
  logic                    o_uart_tx;

  modport master (
    output i_uart_rx,
    input  o_config_bits, o_config_done, o_config_update,
    input  o_config_error, o_error_code, o_busy, o_uart_tx
  );

  modport slave (
    input  i_uart_rx,
    output o_config_bits, o_config_done, o_config_update,
    output o_config_error, o_error_code, o_busy, o_uart_tx
  );
`else
  modport master (
    output i_uart_rx,
    input  o_config_bits, o_config_done, o_config_update,
    input  o_config_error, o_error_code, o_busy
  );

  modport slave (
    input  i_uart_rx,
    output o_config_bits, o_config_done, o_config_update,
    output o_config_error, o_error_code, o_busy
  );
`endif
endinterface

// File: rtl/uart_config_frame.sv
// Framed, XOR-checksummed UART configuration loader (header, NUM_BYTES data, checksum).
// Define UART_CFG_ACK_EN to add an 8N1 ACK (06) / NAK (15) responder on o_uart_tx.
//
// state   | meaning
// HUNT    | waiting for HEADER_BYTE; stray bytes raise code 3
// DATA    | shifting in NUM_BYTES payload bytes, MSB byte first
// CSUM    | expecting the running XOR of the payload
module uart_config_frame #(
  parameter int         CLK_FREQ        = 160,
  parameter int         BAUD_RATE       = 10,
  parameter int         CONFIG_WIDTH    = 52,
  parameter logic [7:0] HEADER_BYTE     = 8'hA5,
  parameter int         TIMEOUT_BITS    = 32,
  parameter bit         LOCK_AFTER_LOAD = 1'b0
) (
  input logic                clk,
  input logic                rst,
  uart_config_frame_if.slave cfg
);
  localparam int BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV  = BAUD_DIV / 2;
  localparam int NUM_BYTES = (CONFIG_WIDTH + 7) / 8;
  localparam int ACC_W     = NUM_BYTES * 8;
  localparam int PAD       = ACC_W - CONFIG_WIDTH;
  localparam int TO_CLKS   = TIMEOUT_BITS * BAUD_DIV;
  localparam int BT_W      = $clog2(BAUD_DIV);
  localparam int TO_W      = $clog2(TO_CLKS + 1);
  localparam int BC_W      = $clog2(NUM_BYTES + 1);
  localparam logic [7:0] PAD_MASK = 8'((32'hFF << (8 - PAD)) & 32'hFF);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;
  typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_CSUM} st_t;

  rx_state_t         r_rx_state;
  logic              r_rx_s1, r_rx_s2, r_rx_prev;
  logic [BT_W-1:0]   r_rx_tmr;
  logic [2:0]        r_rx_bit;
  logic [7:0]        r_rx_sr;

  st_t               r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [7:0]        r_xor;
  logic [BC_W-1:0]   r_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_to_run;

  logic [CONFIG_WIDTH-1:0] r_bits;
  logic              r_done, r_update, r_error, r_busy;
  logic [2:0]        r_code;

  logic w_lock, w_tick, w_start_edge, w_false_start, w_byte_vld, w_frame_err;
  logic w_timeout, w_pad_bad, w_commit, w_err_evt, w_abort;
  logic [2:0] w_err_code;

  assign w_lock        = LOCK_AFTER_LOAD && r_done;
  assign w_tick        = (r_rx_tmr == '0);
  assign w_start_edge  = (r_rx_state == RX_IDLE) && r_rx_prev && !r_rx_s2 && !w_lock;
  assign w_false_start = (r_rx_state == RX_START) && w_tick && r_rx_s2;
  assign w_byte_vld    = (r_rx_state == RX_STOP) && w_tick && r_rx_s2;
  assign w_frame_err   = (r_rx_state == RX_STOP) && w_tick && !r_rx_s2;
  assign w_timeout     = r_to_run && (r_to_cnt == '0);

  // Byte receiver: mid-bit sampling from the synchronised falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_tmr   <= '0;
      r_rx_bit   <= '0;
      r_rx_sr    <= '0;
    end else begin
      r_rx_s1   <= cfg.i_uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (!w_tick) r_rx_tmr <= r_rx_tmr - 1'b1;
      case (r_rx_state)
        RX_IDLE: if (w_start_edge) begin
          r_rx_state <= RX_START;
          r_rx_tmr   <= BT_W'(HALF_DIV - 1);
        end
        RX_START: if (w_tick) begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
          else begin
            r_rx_state <= RX_DATA;
            r_rx_tmr   <= BT_W'(BAUD_DIV - 1);
            r_rx_bit   <= '0;
          end
        end
        RX_DATA: if (w_tick) begin
          r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
          r_rx_tmr <= BT_W'(BAUD_DIV - 1);
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          else r_rx_bit <= r_rx_bit + 1'b1;
        end
        RX_STOP: if (w_tick) r_rx_state <= r_rx_s2 ? RX_IDLE : RX_WAIT_HI;
        RX_WAIT_HI: if (r_rx_s2) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Event decode shared by the frame FSM and the optional responder.
  always_comb begin
    w_pad_bad  = (r_state == ST_DATA) && (r_cnt == '0) && ((r_rx_sr & PAD_MASK) != 8'h00);
    w_commit   = w_byte_vld && (r_state == ST_CSUM) && (r_rx_sr == r_xor);
    w_err_evt  = 1'b0;
    w_err_code = 3'd0;
    if (w_timeout) begin
      w_err_evt  = 1'b1;
      w_err_code = 3'd6;
    end else if (w_frame_err) begin
      w_err_evt  = 1'b1;
      w_err_code = 3'd1;
    end else if (w_false_start) begin
      w_err_evt  = 1'b1;
      w_err_code = 3'd2;
    end else if (w_byte_vld) begin
      case (r_state)
        ST_HUNT: if (r_rx_sr != HEADER_BYTE) begin
          w_err_evt  = 1'b1;
          w_err_code = 3'd3;
        end
        ST_DATA: if (w_pad_bad) begin
          w_err_evt  = 1'b1;
          w_err_code = 3'd4;
        end
        ST_CSUM: if (r_rx_sr != r_xor) begin
          w_err_evt  = 1'b1;
          w_err_code = 3'd5;
        end
        default: ;
      endcase
    end
    w_abort = w_err_evt && (r_state != ST_HUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_HUNT;
      r_acc    <= '0;
      r_xor    <= '0;
      r_cnt    <= '0;
      r_to_cnt <= '0;
      r_to_run <= 1'b0;
      r_bits   <= '0;
      r_done   <= 1'b0;
      r_update <= 1'b0;
      r_error  <= 1'b0;
      r_code   <= 3'd0;
      r_busy   <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (r_to_run) begin
        if (w_start_edge) r_to_run <= 1'b0;
        else if (r_to_cnt != '0) r_to_cnt <= r_to_cnt - 1'b1;
      end
      if (w_err_evt) begin
        r_error <= 1'b1;
        r_code  <= w_err_code;
      end
      if (w_abort) begin
        r_state  <= ST_HUNT;
        r_busy   <= 1'b0;
        r_to_run <= 1'b0;
      end else if (w_commit) begin
        r_bits   <= r_acc[CONFIG_WIDTH-1:0];
        r_update <= 1'b1;
        r_done   <= 1'b1;
        r_error  <= 1'b0;
        r_code   <= 3'd0;
        r_busy   <= 1'b0;
        r_to_run <= 1'b0;
        r_state  <= ST_HUNT;
      end else if (w_byte_vld) begin
        case (r_state)
          ST_HUNT: if (r_rx_sr == HEADER_BYTE) begin
            r_state  <= ST_DATA;
            r_acc    <= '0;
            r_xor    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_to_run <= 1'b1;
            r_to_cnt <= TO_W'(TO_CLKS - 1);
          end
          ST_DATA: begin
            r_acc    <= (r_acc << 8) | ACC_W'(r_rx_sr);
            r_xor    <= r_xor ^ r_rx_sr;
            r_cnt    <= r_cnt + 1'b1;
            r_to_run <= 1'b1;
            r_to_cnt <= TO_W'(TO_CLKS - 1);
            if (r_cnt == BC_W'(NUM_BYTES - 1)) r_state <= ST_CSUM;
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg.o_config_bits   = r_bits;
  assign cfg.o_config_done   = r_done;
  assign cfg.o_config_update = r_update;
  assign cfg.o_config_error  = r_error;
  assign cfg.o_error_code    = r_code;
  assign cfg.o_busy          = r_busy;

`ifdef UART_CFG_ACK_EN
  logic       w_ack_req;
  logic [7:0] w_ack_byte;
  logic       r_tx_busy, r_tx_line, r_pend_vld;
  logic [7:0] r_pend_byte;
  logic [8:0] r_tx_sr;
  logic [3:0] r_tx_bits;
  logic [BT_W-1:0] r_tx_tmr;

  assign w_ack_req  = w_commit || w_abort;
  assign w_ack_byte = w_commit ? 8'h06 : 8'h15;

  // One-deep pending slot; a newer response replaces an unsent one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_busy   <= 1'b0;
      r_tx_line   <= 1'b1;
      r_pend_vld  <= 1'b0;
      r_pend_byte <= '0;
      r_tx_sr     <= '1;
      r_tx_bits   <= '0;
      r_tx_tmr    <= '0;
    end else begin
      if (!r_tx_busy && r_pend_vld) r_pend_vld <= 1'b0;
      if (w_ack_req && (r_tx_busy || r_pend_vld)) begin
        r_pend_vld  <= 1'b1;
        r_pend_byte <= w_ack_byte;
      end
      if (!r_tx_busy) begin
        if (r_pend_vld || w_ack_req) begin
          r_tx_busy <= 1'b1;
          r_tx_line <= 1'b0;
          r_tx_sr   <= {1'b1, (r_pend_vld ? r_pend_byte : w_ack_byte)};
          r_tx_bits <= 4'd9;
          r_tx_tmr  <= BT_W'(BAUD_DIV - 1);
        end
      end else if (r_tx_tmr != '0) begin
        r_tx_tmr <= r_tx_tmr - 1'b1;
      end else if (r_tx_bits == 4'd0) begin
        r_tx_busy <= 1'b0;
      end else begin
        r_tx_line <= r_tx_sr[0];
        r_tx_sr   <= {1'b1, r_tx_sr[8:1]};
        r_tx_bits <= r_tx_bits - 1'b1;
        r_tx_tmr  <= BT_W'(BAUD_DIV - 1);
      end
    end
  end

  assign cfg.o_uart_tx = r_tx_line;
`endif
endmodule

// File: tb/tb_uart_config_frame.sv
// Bench for uart_config_frame: an unlocked and a LOCK_AFTER_LOAD instance share one RX line
// and are checked against a byte-level frame model after each directed or random frame.
module tb_uart_config_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  always #5 clk = ~clk;

  uart_config_frame_if #(.CONFIG_WIDTH(52)) if0 ();
  uart_config_frame_if #(.CONFIG_WIDTH(52)) if1 ();
  assign if0.i_uart_rx = rx;
  assign if1.i_uart_rx = rx;

  uart_config_frame #(.LOCK_AFTER_LOAD(1'b0)) u_dut  (.clk(clk), .rst(rst), .cfg(if0));
  uart_config_frame #(.LOCK_AFTER_LOAD(1'b1)) u_lock (.clk(clk), .rst(rst), .cfg(if1));

  int n_asserts = 0;
  int n_fail    = 0;
  int upd_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    if (if0.o_config_update === 1'b1) upd_cnt[0]++;
    if (if1.o_config_update === 1'b1) upd_cnt[1]++;
  end

  // Frame-level reference model, one copy per instance (index 1 = locking variant).
  logic [51:0] m_bits[2];
  logic        m_done[2], m_err[2], m_busy[2];
  logic [2:0]  m_code[2];
  int          m_upd[2] = '{0, 0};
  logic [7:0]  m_data[2][7];
  int          m_n[2];

  function automatic bit m_live(input int k);
    return !(k == 1 && m_done[1]);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_bits[k] = '0; m_done[k] = 1'b0; m_err[k] = 1'b0;
      m_busy[k] = 1'b0; m_code[k] = 3'd0; m_n[k] = 0;
    end
  endtask

  task automatic m_fail(input int k, input logic [2:0] c);
    m_err[k] = 1'b1; m_code[k] = c; m_busy[k] = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    logic [63:0] v;
    logic [7:0]  x;
    for (int k = 0; k < 2; k++) begin
      if (m_live(k)) begin
        if (!m_busy[k]) begin
          if (b == 8'hA5) begin m_busy[k] = 1'b1; m_n[k] = 0; end
          else m_fail(k, 3'd3);
        end else if (m_n[k] < 7) begin
          if (m_n[k] == 0 && b[7:4] != 4'h0) m_fail(k, 3'd4);
          else begin m_data[k][m_n[k]] = b; m_n[k]++; end
        end else begin
          v = '0; x = '0;
          for (int j = 0; j < 7; j++) begin
            v = (v << 8) | 64'(m_data[k][j]);
            x = x ^ m_data[k][j];
          end
          if (x == b) begin
            m_bits[k] = v[51:0]; m_done[k] = 1'b1; m_err[k] = 1'b0;
            m_code[k] = 3'd0; m_busy[k] = 1'b0; m_upd[k]++;
          end else m_fail(k, 3'd5);
        end
      end
    end
  endtask

  task automatic m_line_err(input logic [2:0] c);
    for (int k = 0; k < 2; k++) if (m_live(k)) m_fail(k, c);
  endtask

  task automatic m_idle_timeout();
    for (int k = 0; k < 2; k++) if (m_live(k) && m_busy[k]) m_fail(k, 3'd6);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, " bits0"}, 64'(if0.o_config_bits),  64'(m_bits[0]));
    chk({tag, " done0"}, 64'(if0.o_config_done),  64'(m_done[0]));
    chk({tag, " err0"},  64'(if0.o_config_error), 64'(m_err[0]));
    chk({tag, " code0"}, 64'(if0.o_error_code),   64'(m_code[0]));
    chk({tag, " busy0"}, 64'(if0.o_busy),         64'(m_busy[0]));
    chk({tag, " upd0"},  64'(upd_cnt[0]),         64'(m_upd[0]));
    chk({tag, " bits1"}, 64'(if1.o_config_bits),  64'(m_bits[1]));
    chk({tag, " done1"}, 64'(if1.o_config_done),  64'(m_done[1]));
    chk({tag, " err1"},  64'(if1.o_config_error), 64'(m_err[1]));
    chk({tag, " code1"}, 64'(if1.o_error_code),   64'(m_code[1]));
    chk({tag, " busy1"}, 64'(if1.o_busy),         64'(m_busy[1]));
    chk({tag, " upd1"},  64'(upd_cnt[1]),         64'(m_upd[1]));
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (16) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b1);
    m_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] f[9]);
    for (int i = 0; i < 9; i++) send_byte(f[i]);
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  logic [7:0] f_good[9] = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0] f_rel[9]  = '{8'hA5, 8'h05, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h05};
  logic [7:0] f_bad[9]  = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'h00};

  initial begin
    logic [51:0] rv;
    logic [55:0] w;
    logic [7:0]  fr[9];
    logic [7:0]  cs;
    int          kind;

    do_reset();
    check_all("reset");

    // Framing error on third byte, then a short glitch
    send_byte(8'hA5);
    send_byte(8'h01);
    send_bits(8'h23, 1'b0);
    m_line_err(3'd1);
    check_all("framing");
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    m_line_err(3'd2);
    check_all("glitch");

    send_byte(8'h3C);
    check_all("bad header");
    send_byte(8'hA5);
    send_byte(8'hF0);
    check_all("pad");

    send_frame(f_good);
    check_all("load");
    chk("load bits const", 64'(if0.o_config_bits), 64'h1_2345_6789_ABCD);
    send_frame(f_rel);
    check_all("reload");
    chk("reload bits const", 64'(if0.o_config_bits), 64'h5_5555_5555_5555);
    chk("lock bits const", 64'(if1.o_config_bits), 64'h1_2345_6789_ABCD);
    send_frame(f_bad);
    check_all("checksum");
    send_frame(f_good);
    check_all("recover");

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (600) @(negedge clk);
    m_idle_timeout();
    check_all("timeout");

    send_byte(8'hA5);
    send_byte(8'h0D);
    send_byte(8'hEA);
    do_reset();
    check_all("mid reset");
    send_frame(f_good);
    check_all("post reset load");

    for (int it = 0; it < 16; it++) begin
      if (it % 5 == 4) begin
        do_reset();
        check_all("rand reset");
      end
      rv = {$urandom(), $urandom()};
      w  = {4'h0, rv};
      cs = '0;
      fr[0] = 8'hA5;
      for (int j = 0; j < 7; j++) begin
        fr[j+1] = w[55-8*j -: 8];
        cs = cs ^ fr[j+1];
      end
      fr[8] = cs;
      kind = int'($urandom_range(0, 3));
      if (kind == 1) fr[8] = cs ^ 8'(1 << $urandom_range(0, 7));
      else if (kind == 2) fr[0] = 8'h5A ^ 8'(1 << $urandom_range(0, 7));
      else if (kind == 3) fr[1] = fr[1] | 8'(8'h10 << $urandom_range(0, 3));
      for (int i = 0; i < 9; i++) begin
        send_byte(fr[i]);
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      check_all("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
